// File: rtl/core_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: register index width,
// the tracked pipeline-slot entry and the "read from register file" select code.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rd;
    } slot_t;

endpackage

// File: rtl/hazard_port_check.sv
// Youngest-match search for one source operand over the post-decode slots.
// Returns a stall request or the slot number to forward from.
module hazard_port_check
    import core_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned ALU_READY  = 1,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned FWD_W      = 2
) (
    input  slot_t [PIPE_DEPTH-1:0] i_slots,
    input  logic  [REG_ADDR_W-1:0] i_rs,
    input  logic                   i_rs_used,
    output logic                   o_stall_req_c,
    output logic  [FWD_W-1:0]      o_fwd_sel_c
);

    logic w_found;

    // Index 0 is slot1 (youngest); the first hit stops the search, so older
    // writers of the same register are shadowed even when they are ready.
    always_comb begin
        o_stall_req_c = 1'b0;
        o_fwd_sel_c   = FWD_W'(FWD_RF);
        w_found       = 1'b0;
        for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            if (!w_found && i_rs_used && (i_rs != '0) && i_slots[k].valid &&
                i_slots[k].regwrite && (i_slots[k].rd == i_rs)) begin
                w_found = 1'b1;
                if ((k + 1) >= (i_slots[k].is_load ? LOAD_READY : ALU_READY)) begin
                    o_fwd_sel_c = FWD_W'(k + 1);
                end else begin
                    o_stall_req_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: tracks in-flight register writes across the post-decode
// slots and decides, per source operand, between stalling and forwarding.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned REG_ADDR_W   = core_pkg::REG_ADDR_W,
    parameter int unsigned PIPE_DEPTH   = 3,
    parameter int unsigned ALU_READY    = 1,
    parameter int unsigned LOAD_READY   = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned FWD_W        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue_valid,
    input  logic                             issue_regwrite,
    input  logic                             issue_is_load,
    input  logic [REG_ADDR_W-1:0]            issue_rd,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] issue_rs,
    input  logic [NUM_RD_PORTS-1:0]          issue_rs_used,
    input  logic [PIPE_DEPTH-1:0]            flush_mask,
    output logic                             stall,
    output logic [NUM_RD_PORTS*FWD_W-1:0]    fwd_sel,
    output logic [FWD_W-1:0]                 inflight,
    output logic [CNT_W-1:0]                 stall_count
);

    localparam int unsigned SLOT_RD_W = core_pkg::REG_ADDR_W;

    slot_t [PIPE_DEPTH-1:0]   r_slot;
    slot_t [PIPE_DEPTH-1:0]   w_live;
    slot_t                    w_issue;
    logic  [NUM_RD_PORTS-1:0] w_port_stall;
    logic  [CNT_W-1:0]        r_stall_count;

    // Flushed entries vanish this cycle: no match, not counted, advance invalid.
    always_comb begin
        w_live = r_slot;
        for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            w_live[k].valid = r_slot[k].valid & ~flush_mask[k];
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        hazard_port_check #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .ALU_READY  (ALU_READY),
            .LOAD_READY (LOAD_READY),
            .FWD_W      (FWD_W)
        ) u_check (
            .i_slots       (w_live),
            .i_rs          (SLOT_RD_W'(issue_rs[p*REG_ADDR_W +: REG_ADDR_W])),
            .i_rs_used     (issue_rs_used[p]),
            .o_stall_req_c (w_port_stall[p]),
            .o_fwd_sel_c   (fwd_sel[p*FWD_W +: FWD_W])
        );
    end

    always_comb begin
        stall = (|w_port_stall) & issue_valid & ~flush_mask[0];
    end

    // A stalled or squashed issue enters slot1 as a bubble.
    always_comb begin
        w_issue.valid    = issue_valid & ~stall & ~flush_mask[0];
        w_issue.regwrite = issue_regwrite;
        w_issue.is_load  = issue_is_load;
        w_issue.rd       = SLOT_RD_W'(issue_rd);
    end

    always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            inflight = inflight + FWD_W'(w_live[k].valid);
        end
    end

    // Slots shift every cycle; there is no downstream backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot        <= '0;
            r_stall_count <= '0;
        end else begin
            r_slot <= {w_live[PIPE_DEPTH-2:0], w_issue};
            if (stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_stall_count;

endmodule
